trng_harvest_ctrl: RTL and testbench

Controller that sequences an array of single-bit TRNG sources, each with an EN / RANDOM / BIT_READY / ACK interface. It enables the array, collects one bit per source per batch with per-source acknowledge, and packs batches into a word. The finished word goes to a consumer (display decoder or bus) over a valid/ready handshake. It sits between the TRNG instances and the board I/O, replacing ad-hoc button-driven capture logic.

---
 rtl/trng_harvest_ctrl.sv | 131 +++++++++++++
 tb/tb_trng_harvest_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_harvest_ctrl.sv
// Collects one bit per TRNG source per batch and packs batches MSB-first into a word.
// Best case one word in 2*(WORD_WIDTH/NUM_SRC)+1 cycles; the word is held until WORD_READY.
module trng_harvest_ctrl #(
    parameter int NUM_SRC    = 16,
    parameter int WORD_WIDTH = 16,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req,
    output logic                  o_src_en,
    input  logic [NUM_SRC-1:0]    i_src_ready,
    input  logic [NUM_SRC-1:0]    i_src_bit,
    output logic [NUM_SRC-1:0]    o_src_ack,
    output logic [WORD_WIDTH-1:0] o_word,
    output logic                  o_word_valid,
    input  logic                  i_word_ready,
    output logic                  o_busy,
    output logic                  o_timeout_err
);
    localparam int NB = WORD_WIDTH / NUM_SRC;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HARVEST = 2'd1;
    localparam logic [1:0] S_SHIFT   = 2'd2;
    localparam logic [1:0] S_PRESENT = 2'd3;

    logic [1:0]            r_state;
    logic [NUM_SRC-1:0]    r_seen;
    logic [NUM_SRC-1:0]    r_cap;
    logic [NUM_SRC-1:0]    r_ack;
    logic [TW-1:0]         r_timer;
    logic [BW-1:0]         r_batch;
    logic [WORD_WIDTH-1:0] r_word;
    logic                  r_err;

    logic [NUM_SRC-1:0]    w_new;
    logic                  w_all;
    logic [TW-1:0]         w_timer_inc;
    logic [WORD_WIDTH-1:0] w_shift_next;

    // A source counts once per batch: later READY pulses are ignored until the seen mask clears.
    assign w_new       = i_src_ready & ~r_seen;
    assign w_all       = &(r_seen | i_src_ready);
    assign w_timer_inc = r_timer + 1'b1;

    generate
        if (NB == 1) begin : g_single
            assign w_shift_next = r_cap;
        end else begin : g_multi
            logic [WORD_WIDTH-NUM_SRC-1:0] r_hist;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n)
                    r_hist <= '0;
                else if (r_state == S_IDLE && i_req)
                    r_hist <= '0;
                else if (r_state == S_SHIFT)
                    r_hist <= w_shift_next[WORD_WIDTH-NUM_SRC-1:0];
            end
            assign w_shift_next = {r_hist, r_cap};
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_seen  <= '0;
            r_cap   <= '0;
            r_ack   <= '0;
            r_timer <= '0;
            r_batch <= '0;
            r_word  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_ack <= '0;
            case (r_state)
                S_IDLE: begin
                    if (i_req) begin
                        r_state <= S_HARVEST;
                        r_seen  <= '0;
                        r_cap   <= '0;
                        r_timer <= '0;
                        r_batch <= '0;
                        r_word  <= '0;
                        r_err   <= 1'b0;
                    end
                end
                S_HARVEST: begin
                    r_ack  <= w_new;
                    r_seen <= r_seen | w_new;
                    r_cap  <= (r_cap & ~w_new) | (i_src_bit & w_new);
                    // Completion wins over timeout when both land in the same cycle.
                    if (w_all) begin
                        r_state <= S_SHIFT;
                    end else begin
                        r_timer <= w_timer_inc;
                        if (w_timer_inc == TW'(TIMEOUT)) begin
                            r_err   <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_SHIFT: begin
                    r_seen  <= '0;
                    r_timer <= '0;
                    if (r_batch == BW'(NB - 1)) begin
                        r_state <= S_PRESENT;
                        r_word  <= w_shift_next;
                    end else begin
                        r_batch <= r_batch + 1'b1;
                        r_state <= S_HARVEST;
                    end
                end
                S_PRESENT: begin
                    if (i_word_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_src_en      = (r_state == S_HARVEST) || (r_state == S_SHIFT);
    assign o_busy        = (r_state != S_IDLE);
    assign o_word_valid  = (r_state == S_PRESENT);
    assign o_src_ack     = r_ack;
    assign o_word        = r_word;
    assign o_timeout_err = r_err;
endmodule

// File: tb/tb_trng_harvest_ctrl.sv
// Bench for trng_harvest_ctrl: a 16x16 and a 4x16 instance driven from per-cycle vector tables built from batch schedules.
module tb_trng_harvest_ctrl;
    localparam int TMO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        a_req, a_wrdy, a_en, a_valid, a_busy, a_err;
    logic [15:0] a_rdy, a_bit, a_ack, a_word;
    logic        b_req, b_wrdy, b_en, b_valid, b_busy, b_err;
    logic [3:0]  b_rdy, b_bit, b_ack;
    logic [15:0] b_word;

    trng_harvest_ctrl #(.NUM_SRC(16), .WORD_WIDTH(16), .TIMEOUT(TMO)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(a_req), .o_src_en(a_en),
        .i_src_ready(a_rdy), .i_src_bit(a_bit), .o_src_ack(a_ack),
        .o_word(a_word), .o_word_valid(a_valid), .i_word_ready(a_wrdy),
        .o_busy(a_busy), .o_timeout_err(a_err));

    trng_harvest_ctrl #(.NUM_SRC(4), .WORD_WIDTH(16), .TIMEOUT(TMO)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(b_req), .o_src_en(b_en),
        .i_src_ready(b_rdy), .i_src_bit(b_bit), .o_src_ack(b_ack),
        .o_word(b_word), .o_word_valid(b_valid), .i_word_ready(b_wrdy),
        .o_busy(b_busy), .o_timeout_err(b_err));

    typedef struct {
        logic        req;
        logic [15:0] rdy;
        logic [15:0] bt;
        logic        wrdy;
        logic        busy;
        logic        en;
        logic        valid;
        logic        err;
        logic [15:0] ack;
        logic [15:0] word;
    } vec_t;

    vec_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          n_src;
    logic [15:0] mask, m_word, m_ack, acc;
    logic        m_err;
    int          sd_tab[4][16];
    logic [15:0] sb_tab[4];

    function automatic logic [15:0] rnd();
        return 16'($urandom()) & mask;
    endfunction

    task automatic chk(input string nm, input int cyc, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset(input int n);
        n_src  = n;
        mask   = (n == 16) ? 16'hFFFF : 16'((32'd1 << n) - 1);
        m_word = '0;
        m_ack  = '0;
        m_err  = 1'b0;
        acc    = '0;
        q.delete();
    endtask

    task automatic push(input logic req, input logic [15:0] rdy, input logic [15:0] bt,
                        input logic wrdy, input logic busy, input logic en, input logic valid);
        vec_t v;
        v.req = req; v.rdy = rdy; v.bt = bt; v.wrdy = wrdy;
        v.busy = busy; v.en = en; v.valid = valid;
        v.err = m_err; v.ack = m_ack; v.word = m_word;
        q.push_back(v);
        m_ack = '0;
    endtask

    task automatic idle_gap(input int g);
        repeat (g) push(1'b0, rnd(), rnd(), 1'($urandom()), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic request();
        push(1'b1, rnd(), rnd(), 1'($urandom()), 1'b0, 1'b0, 1'b0);
        m_word = '0;
        m_err  = 1'b0;
    endtask

    // Source i first raises READY at offset sd_tab[b][i] into the batch; after capture READY/BIT are noise.
    task automatic batch(input int b, output bit ok);
        int d_max;
        int len;
        d_max = 0;
        for (int i = 0; i < n_src; i++)
            if (sd_tab[b][i] > d_max) d_max = sd_tab[b][i];
        len = (d_max < TMO) ? d_max + 1 : TMO;
        for (int k = 0; k < len; k++) begin
            logic [15:0] rdy, bt, nm;
            rdy = '0; bt = rnd(); nm = '0;
            for (int i = 0; i < n_src; i++) begin
                if (k == sd_tab[b][i]) begin
                    rdy[i] = 1'b1; bt[i] = sb_tab[b][i]; nm[i] = 1'b1;
                end else if (k > sd_tab[b][i]) begin
                    rdy[i] = 1'($urandom());
                end
            end
            push(1'($urandom()), rdy, bt, 1'($urandom()), 1'b1, 1'b1, 1'b0);
            m_ack = nm;
        end
        ok = (d_max < TMO);
        if (!ok) begin
            m_err = 1'b1;
        end else begin
            push(1'($urandom()), rnd(), rnd(), 1'($urandom()), 1'b1, 1'b1, 1'b0);
            acc = (acc << n_src) | (sb_tab[b] & mask);
        end
    endtask

    task automatic word_txn(input int gap, input int pwait);
        bit ok;
        int nb;
        ok = 1'b1;
        nb = 16 / n_src;
        idle_gap(gap);
        request();
        acc = '0;
        for (int b = 0; b < nb && ok; b++) batch(b, ok);
        if (ok) begin
            m_word = acc;
            repeat (pwait) push(1'($urandom()), rnd(), rnd(), 1'b0, 1'b1, 1'b0, 1'b1);
            push(1'($urandom()), rnd(), rnd(), 1'b1, 1'b1, 1'b0, 1'b1);
        end
    endtask

    task automatic rand_sched(input bit allow_to);
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 16; i++)
                sd_tab[b][i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 3));
            sb_tab[b] = rnd();
        end
        if (allow_to && $urandom_range(0, 5) == 0)
            sd_tab[$urandom_range(0, 3)][$urandom_range(0, n_src - 1)] = 100;
    endtask

    task automatic run_table(input int dut);
        for (int i = 0; i < q.size(); i++) begin
            logic        busy, en, valid, err;
            logic [15:0] ack, word;
            @(negedge clk);
            if (dut == 0) begin
                busy = a_busy; en = a_en; valid = a_valid; err = a_err; ack = a_ack; word = a_word;
            end else begin
                busy = b_busy; en = b_en; valid = b_valid; err = b_err; ack = {12'b0, b_ack}; word = b_word;
            end
            chk("busy", i, {15'b0, busy}, {15'b0, q[i].busy});
            chk("src_en", i, {15'b0, en}, {15'b0, q[i].en});
            chk("word_valid", i, {15'b0, valid}, {15'b0, q[i].valid});
            chk("timeout_err", i, {15'b0, err}, {15'b0, q[i].err});
            chk("src_ack", i, ack, q[i].ack);
            chk("word", i, word, q[i].word);
            if (dut == 0) begin
                a_req = q[i].req; a_rdy = q[i].rdy; a_bit = q[i].bt; a_wrdy = q[i].wrdy;
            end else begin
                b_req = q[i].req; b_rdy = q[i].rdy[3:0]; b_bit = q[i].bt[3:0]; b_wrdy = q[i].wrdy;
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a_en"}, -1, {15'b0, a_en}, 16'h0);
        chk({tag, "_a_busy"}, -1, {15'b0, a_busy}, 16'h0);
        chk({tag, "_a_valid"}, -1, {15'b0, a_valid}, 16'h0);
        chk({tag, "_a_err"}, -1, {15'b0, a_err}, 16'h0);
        chk({tag, "_a_ack"}, -1, a_ack, 16'h0);
        chk({tag, "_a_word"}, -1, a_word, 16'h0);
        chk({tag, "_b_busy"}, -1, {15'b0, b_busy | b_en | b_valid | b_err}, 16'h0);
        chk({tag, "_b_ack_word"}, -1, {12'b0, b_ack} | b_word, 16'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        mask  = 16'hFFFF;
        repeat (3) begin
            a_req = 1'($urandom()); a_rdy = rnd(); a_bit = rnd(); a_wrdy = 1'($urandom());
            b_req = 1'($urandom()); b_rdy = 4'($urandom()); b_bit = 4'($urandom()); b_wrdy = 1'($urandom());
            @(negedge clk);
            chk_zero("reset");
        end
        a_req = 1'b0; a_rdy = '0; a_bit = '0; a_wrdy = 1'b0;
        b_req = 1'b0; b_rdy = '0; b_bit = '0; b_wrdy = 1'b0;
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk_zero("post_reset");
        end

        // 16-source instance: single batch, staggered ready, timeout, then random words
        model_reset(16);
        for (int i = 0; i < 16; i++) sd_tab[0][i] = 0;
        sb_tab[0] = 16'hA5C3;
        word_txn(1, 2);
        for (int i = 0; i < 16; i++) sd_tab[0][i] = 3;
        sd_tab[0][3] = 0;
        sb_tab[0] = rnd() | 16'h0008;
        word_txn(1, 0);
        for (int i = 0; i < 16; i++) sd_tab[0][i] = int'($urandom_range(0, 3));
        sd_tab[0][7] = 100;
        sb_tab[0] = rnd();
        word_txn(2, 0);
        repeat (15) begin
            rand_sched(1'b1);
            word_txn(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end
        idle_gap(2);
        run_table(0);

        // Reset while two sources are captured and their ACKs are in flight
        @(negedge clk);
        a_req = 1'b1; a_rdy = '0; a_wrdy = 1'b0;
        @(negedge clk);
        chk("mid_busy", -1, {15'b0, a_busy}, 16'h0001);
        a_req = 1'b0; a_rdy = 16'h0003; a_bit = 16'h0002;
        @(posedge clk);
        #1;
        chk("mid_ack", -1, a_ack, 16'h0003);
        a_rdy = '0;
        rst_n = 1'b0;
        #1;
        chk_zero("mid_reset");
        @(negedge clk);
        chk_zero("mid_reset_hold");
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_zero("mid_post");
        end

        // 4-source instance: four batches 1,2,3,4 then random words
        model_reset(4);
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 16; i++) sd_tab[b][i] = int'($urandom_range(0, 2));
            sb_tab[b] = 16'(b + 1);
        end
        word_txn(1, 1);
        repeat (12) begin
            rand_sched(1'b1);
            word_txn(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end
        idle_gap(2);
        run_table(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
